// File: rtl/conv_event_out_serializer.sv
// conv_event_out_serializer
// Buffers packed output spikes {x, y, mask} from the convolution controller
// in a FIFO (backpressure via output_fifo_full) and serializes each mask into
// one {x, y, ch} event per set bit over a valid/ready handshake. Timestep
// boundaries travel in-band as marker entries/beats.
//
// Ports:
//   clk, rst_n        clock, asynchronous active-low reset
//   write_enable      controller writes spike_in this cycle
//   spike_in          {x, y, mask}, x in the MSBs
//   timestep          one-cycle end-of-timestep pulse
//   output_fifo_full  FIFO holds FIFO_DEPTH entries
//   fifo_empty        FIFO holds no entries
//   out_valid         out_event / out_marker valid
//   out_ready         downstream accepts the beat
//   out_event         {x, y, ch}; zero on marker beats
//   out_marker        beat is a timestep marker
//   busy              FIFO non-empty, serializer active, or marker pending
//
// Optional build macro OUT_EVENT_DROP_CNT_EN adds:
//   drop_clr          synchronous clear of drop_count
//   drop_count        saturating count of spikes refused while full
module conv_event_out_serializer #(
    parameter int unsigned COORD_BITS      = 8,
    parameter int unsigned CHANNELS        = 6,
    parameter int unsigned CH_BITS         = $clog2(CHANNELS),
    parameter int unsigned FIFO_DEPTH      = 16,
    parameter int unsigned FIFO_ADDR_WIDTH = $clog2(FIFO_DEPTH)
) (
    input  logic                              clk,
    input  logic                              rst_n,
    input  logic                              write_enable,
    input  logic [2*COORD_BITS+CHANNELS-1:0]  spike_in,
    input  logic                              timestep,
    output logic                              output_fifo_full,
    output logic                              fifo_empty,
    output logic                              out_valid,
    input  logic                              out_ready,
    output logic [2*COORD_BITS+CH_BITS-1:0]   out_event,
    output logic                              out_marker,
    output logic                              busy
`ifdef OUT_EVENT_DROP_CNT_EN
    ,
    input  logic                              drop_clr,
    output logic [15:0]                       drop_count
`endif
);

    localparam int unsigned XY_W    = 2 * COORD_BITS;
    localparam int unsigned SPIKE_W = XY_W + CHANNELS;
    localparam int unsigned ENTRY_W = SPIKE_W + 1;
    localparam int unsigned CNT_W   = FIFO_ADDR_WIDTH + 1;

    typedef enum logic [1:0] {
        S_IDLE,
        S_LOAD,
        S_EMIT,
        S_MARK
    } state_t;

    // Index of the lowest set bit of a mask (0 when the mask is empty).
    function automatic logic [CH_BITS-1:0] lowest_bit(input logic [CHANNELS-1:0] m);
        lowest_bit = '0;
        for (int i = CHANNELS - 1; i >= 0; i--) begin
            if (m[i]) lowest_bit = CH_BITS'(i);
        end
    endfunction

    logic [ENTRY_W-1:0]         mem [FIFO_DEPTH];
    logic [FIFO_ADDR_WIDTH-1:0] wr_ptr;
    logic [FIFO_ADDR_WIDTH-1:0] rd_ptr;
    logic [CNT_W-1:0]           count;
    logic                       pending_marker;

    state_t                     state;
    logic [XY_W-1:0]            hold_xy;
    logic [CHANNELS-1:0]        hold_mask;
    logic                       hold_mflag;
    logic [CH_BITS-1:0]         hold_ch;

    logic                       full_c;
    logic                       empty_c;
    logic                       spike_ok_c;
    logic                       push_spike_c;
    logic                       push_mark_c;
    logic                       push_c;
    logic                       pop_c;
    logic                       pending_next_c;
    logic                       idle_next_c;
    logic [ENTRY_W-1:0]         push_data_c;
    logic [CNT_W-1:0]           count_next_c;
    logic [CHANNELS-1:0]        rem_mask_c;

    // Write-side arbitration: full is judged on the pre-pop count.
    always_comb begin
        full_c         = (count == CNT_W'(FIFO_DEPTH));
        empty_c        = (count == '0);
        spike_ok_c     = write_enable && (spike_in[CHANNELS-1:0] != '0);
        push_spike_c   = spike_ok_c && !full_c;
        // A pending marker absorbs any new timestep, so the spike only
        // carries the marker flag when nothing is already pending.
        push_mark_c    = !push_spike_c && (timestep || pending_marker) && !full_c;
        push_c         = push_spike_c || push_mark_c;
        push_data_c    = push_spike_c ? {timestep && !pending_marker, spike_in}
                                      : {1'b1, SPIKE_W'(0)};
        pop_c          = (state == S_IDLE) && !empty_c;
        count_next_c   = count + CNT_W'(push_c) - CNT_W'(pop_c);
        pending_next_c = pending_marker;
        if ((timestep || pending_marker) && full_c) begin
            pending_next_c = 1'b1;
        end else if (push_mark_c) begin
            pending_next_c = 1'b0;
        end
    end

    // Mask left after the current channel is accepted, and whether the FSM
    // lands in IDLE at the next edge (feeds the registered busy flag).
    always_comb begin
        rem_mask_c  = hold_mask & ~(CHANNELS'(1) << hold_ch);
        idle_next_c = 1'b1;
        case (state)
            S_IDLE:  idle_next_c = empty_c;
            S_LOAD:  idle_next_c = (hold_mask == '0) && !hold_mflag;
            S_EMIT:  idle_next_c = out_ready && (rem_mask_c == '0) && !hold_mflag;
            S_MARK:  idle_next_c = out_ready;
            default: idle_next_c = 1'b1;
        endcase
    end

    // FIFO storage (no reset needed; only written slots are ever read).
    always_ff @(posedge clk) begin
        if (push_c) mem[wr_ptr] <= push_data_c;
    end

    // FIFO pointers, occupancy and pending marker.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr         <= '0;
            rd_ptr         <= '0;
            count          <= '0;
            pending_marker <= 1'b0;
        end else begin
            if (push_c) wr_ptr <= wr_ptr + FIFO_ADDR_WIDTH'(1);
            if (pop_c)  rd_ptr <= rd_ptr + FIFO_ADDR_WIDTH'(1);
            count          <= count_next_c;
            pending_marker <= pending_next_c;
        end
    end

    // Registered status flags, derived from next-cycle state.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            output_fifo_full <= 1'b0;
            fifo_empty       <= 1'b1;
            busy             <= 1'b0;
        end else begin
            output_fifo_full <= (count_next_c == CNT_W'(FIFO_DEPTH));
            fifo_empty       <= (count_next_c == '0);
            busy             <= (count_next_c != '0) || !idle_next_c || pending_next_c;
        end
    end

    // Serializer FSM with registered handshake outputs.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state      <= S_IDLE;
            hold_xy    <= '0;
            hold_mask  <= '0;
            hold_mflag <= 1'b0;
            hold_ch    <= '0;
            out_valid  <= 1'b0;
            out_event  <= '0;
            out_marker <= 1'b0;
        end else begin
            case (state)
                S_IDLE: begin
                    if (pop_c) begin
                        {hold_mflag, hold_xy, hold_mask} <= mem[rd_ptr];
                        state <= S_LOAD;
                    end
                end
                S_LOAD: begin
                    if (hold_mask != '0) begin
                        hold_ch   <= lowest_bit(hold_mask);
                        out_valid <= 1'b1;
                        out_event <= {hold_xy, lowest_bit(hold_mask)};
                        state     <= S_EMIT;
                    end else if (hold_mflag) begin
                        out_valid  <= 1'b1;
                        out_marker <= 1'b1;
                        out_event  <= '0;
                        state      <= S_MARK;
                    end else begin
                        state <= S_IDLE;
                    end
                end
                S_EMIT: begin
                    if (out_ready) begin
                        hold_mask <= rem_mask_c;
                        if (rem_mask_c != '0) begin
                            hold_ch   <= lowest_bit(rem_mask_c);
                            out_event <= {hold_xy, lowest_bit(rem_mask_c)};
                        end else if (hold_mflag) begin
                            out_marker <= 1'b1;
                            out_event  <= '0;
                            state      <= S_MARK;
                        end else begin
                            out_valid <= 1'b0;
                            out_event <= '0;
                            state     <= S_IDLE;
                        end
                    end
                end
                S_MARK: begin
                    if (out_ready) begin
                        out_valid  <= 1'b0;
                        out_marker <= 1'b0;
                        state      <= S_IDLE;
                    end
                end
                default: begin
                    out_valid  <= 1'b0;
                    out_marker <= 1'b0;
                    out_event  <= '0;
                    state      <= S_IDLE;
                end
            endcase
        end
    end

`ifdef OUT_EVENT_DROP_CNT_EN
    logic drop_c;
    assign drop_c = spike_ok_c && full_c;

    // Saturating drop counter; clear wins over a same-cycle drop.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            drop_count <= '0;
        end else if (drop_clr) begin
            drop_count <= '0;
        end else if (drop_c && (drop_count != 16'hFFFF)) begin
            drop_count <= drop_count + 16'd1;
        end
    end
`endif

endmodule
